pkt_transmitter: RTL and testbench

Outgoing-packet serializer for the EER-RL node. Latches one packet's fields (type, source ID, hops, Q-value, energy, hops-from-CH, chosen CH) on a send request. Emits them as a 16-bit word stream over a valid/ready handshake: a header word, then the per-type payload fields, then an XOR checksum word. It is the transmit-side counterpart of the node's packet-field intake path and feeds the radio/MAC word interface.

---
 rtl/eer_pkt_pkg.sv | 57 +++++
 rtl/pkt_type_mask.sv | 30 +++
 rtl/pkt_transmitter.sv | 194 +++++++++++++++++++
 tb/tb_pkt_transmitter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/eer_pkt_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// eer_pkt_pkg : shared packet types, field indices and checksum rule
// Rev 1.0
// ---------------------------------------------------------------------------
package eer_pkt_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int NUM_FIELDS = 6;

    typedef enum logic [2:0] {
        PKT_HELLO    = 3'd0,
        PKT_CH_ELECT = 3'd1,
        PKT_CH_ADV   = 3'd2,
        PKT_JOIN     = 3'd3,
        PKT_DATA     = 3'd4
    } pkt_type_e;

    localparam logic [2:0] FLD_SOURCE_ID   = 3'd0;
    localparam logic [2:0] FLD_SOURCE_HOPS = 3'd1;
    localparam logic [2:0] FLD_QVALUE      = 3'd2;
    localparam logic [2:0] FLD_ENERGY_LEFT = 3'd3;
    localparam logic [2:0] FLD_HOPS_FROM_CH = 3'd4;
    localparam logic [2:0] FLD_CHOSEN_CH   = 3'd5;
    localparam logic [2:0] FLD_NONE        = 3'd6;

    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_HDR     = 2'd1,
        TX_PAYLOAD = 2'd2,
        TX_CSUM    = 2'd3
    } tx_state_e;

    function automatic logic [WORD_WIDTH-1:0] csum_update(
        input logic [WORD_WIDTH-1:0] acc,
        input logic [WORD_WIDTH-1:0] word
    );
        return acc ^ word;
    endfunction

    // Lowest set mask bit at or above 'from'; FLD_NONE when none remain.
    function automatic logic [2:0] next_field(
        input logic [5:0] mask,
        input logic [2:0] from
    );
        logic [2:0] r;
        r = FLD_NONE;
        for (int i = 5; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                r = i[2:0];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_type_mask.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pkt_type_mask : packet type -> field mask, payload word count, valid flag
// Rev 1.0
// ---------------------------------------------------------------------------
module pkt_type_mask
    import eer_pkt_pkg::*;
(
    input  logic [2:0] pkt_type,
    output logic [5:0] mask,
    output logic [2:0] count,
    output logic       valid
);

    always_comb begin
        mask  = 6'b000000;
        count = 3'd0;
        valid = 1'b0;
        case (pkt_type)
            PKT_HELLO:    begin mask = 6'b000011; count = 3'd2; valid = 1'b1; end
            PKT_CH_ELECT: begin mask = 6'b001111; count = 3'd4; valid = 1'b1; end
            PKT_CH_ADV:   begin mask = 6'b011111; count = 3'd5; valid = 1'b1; end
            PKT_JOIN:     begin mask = 6'b101101; count = 3'd4; valid = 1'b1; end
            PKT_DATA:     begin mask = 6'b111111; count = 3'd6; valid = 1'b1; end
            default:      begin mask = 6'b000000; count = 3'd0; valid = 1'b0; end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pkt_transmitter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pkt_transmitter : latches one packet and streams header, payload, checksum
// Rev 1.0
// ---------------------------------------------------------------------------
module pkt_transmitter
    import eer_pkt_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int SEQ_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  send,
    input  logic [2:0]            tPacketType,
    input  logic [WORD_WIDTH-1:0] tSourceID,
    input  logic [WORD_WIDTH-1:0] tSourceHops,
    input  logic [WORD_WIDTH-1:0] tQValue,
    input  logic [WORD_WIDTH-1:0] tEnergyLeft,
    input  logic [WORD_WIDTH-1:0] tHopsFromCH,
    input  logic [WORD_WIDTH-1:0] tChosenCH,
    output logic                  busy,
    output logic                  txReject,
    output logic [WORD_WIDTH-1:0] txWord,
    output logic                  txValid,
    input  logic                  txReady,
    output logic                  txLast,
    output logic                  txDone
);

    localparam logic [1:0] ST_IDLE    = TX_IDLE;
    localparam logic [1:0] ST_HDR     = TX_HDR;
    localparam logic [1:0] ST_PAYLOAD = TX_PAYLOAD;
    localparam logic [1:0] ST_CSUM    = TX_CSUM;

    logic [1:0]            state_q,  state_d;
    logic [WORD_WIDTH-1:0] fields_q [NUM_FIELDS];
    logic [WORD_WIDTH-1:0] fields_d [NUM_FIELDS];
    logic [5:0]            mask_q,   mask_d;
    logic [2:0]            ptr_q,    ptr_d;
    logic [WORD_WIDTH-1:0] csum_q,   csum_d;
    logic [SEQ_WIDTH-1:0]  seq_q,    seq_d;
    logic [WORD_WIDTH-1:0] tx_word_q, tx_word_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  tx_last_q, tx_last_d;
    logic                  tx_done_q, tx_done_d;
    logic                  tx_reject_q, tx_reject_d;
    logic                  busy_q,   busy_d;

    logic [5:0]            type_mask_w;
    logic [2:0]            type_count_w;
    logic                  type_valid_w;
    logic [WORD_WIDTH-1:0] hdr_w;
    logic                  handshake_w;
    logic [2:0]            nxt_ptr_w;
    logic [WORD_WIDTH-1:0] nxt_word_w;

    pkt_type_mask u_type_mask (
        .pkt_type (tPacketType),
        .mask     (type_mask_w),
        .count    (type_count_w),
        .valid    (type_valid_w)
    );

    always_comb begin
        hdr_w = '0;
        hdr_w[WORD_WIDTH-1 -: 3]  = tPacketType;
        hdr_w[WORD_WIDTH-4 -: 6]  = type_mask_w;
        hdr_w[WORD_WIDTH-10 -: 3] = type_count_w;
        hdr_w[SEQ_WIDTH-1:0]      = seq_q;
    end

    assign handshake_w = tx_valid_q && txReady;

    // Search restarts at bit 0 from the header, otherwise just past the current field.
    always_comb begin
        nxt_ptr_w  = next_field(mask_q, (state_q == ST_HDR) ? 3'd0 : ptr_q + 3'd1);
        nxt_word_w = (nxt_ptr_w != FLD_NONE) ? fields_q[nxt_ptr_w] : '0;
    end

    always_comb begin
        state_d     = state_q;
        fields_d    = fields_q;
        mask_d      = mask_q;
        ptr_d       = ptr_q;
        csum_d      = csum_q;
        seq_d       = seq_q;
        tx_word_d   = tx_word_q;
        tx_valid_d  = tx_valid_q;
        tx_last_d   = tx_last_q;
        tx_done_d   = 1'b0;
        tx_reject_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (send) begin
                    if (type_valid_w) begin
                        fields_d[FLD_SOURCE_ID]    = tSourceID;
                        fields_d[FLD_SOURCE_HOPS]  = tSourceHops;
                        fields_d[FLD_QVALUE]       = tQValue;
                        fields_d[FLD_ENERGY_LEFT]  = tEnergyLeft;
                        fields_d[FLD_HOPS_FROM_CH] = tHopsFromCH;
                        fields_d[FLD_CHOSEN_CH]    = tChosenCH;
                        mask_d     = type_mask_w;
                        ptr_d      = 3'd0;
                        seq_d      = seq_q + SEQ_WIDTH'(1);
                        tx_word_d  = hdr_w;
                        csum_d     = hdr_w;
                        tx_valid_d = 1'b1;
                        tx_last_d  = 1'b0;
                        state_d    = ST_HDR;
                    end else begin
                        tx_reject_d = 1'b1;
                    end
                end
            end
            ST_HDR, ST_PAYLOAD: begin
                if (send) begin
                    tx_reject_d = 1'b1;
                end
                if (handshake_w) begin
                    if (nxt_ptr_w == FLD_NONE) begin
                        tx_word_d = csum_q;
                        tx_last_d = 1'b1;
                        state_d   = ST_CSUM;
                    end else begin
                        tx_word_d = nxt_word_w;
                        csum_d    = csum_update(csum_q, nxt_word_w);
                        ptr_d     = nxt_ptr_w;
                        state_d   = ST_PAYLOAD;
                    end
                end
            end
            ST_CSUM: begin
                if (send) begin
                    tx_reject_d = 1'b1;
                end
                if (handshake_w) begin
                    tx_word_d  = '0;
                    tx_valid_d = 1'b0;
                    tx_last_d  = 1'b0;
                    tx_done_d  = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                fields_q[i] <= '0;
            end
            mask_q      <= '0;
            ptr_q       <= '0;
            csum_q      <= '0;
            seq_q       <= '0;
            tx_word_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            tx_done_q   <= 1'b0;
            tx_reject_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fields_q    <= fields_d;
            mask_q      <= mask_d;
            ptr_q       <= ptr_d;
            csum_q      <= csum_d;
            seq_q       <= seq_d;
            tx_word_q   <= tx_word_d;
            tx_valid_q  <= tx_valid_d;
            tx_last_q   <= tx_last_d;
            tx_done_q   <= tx_done_d;
            tx_reject_q <= tx_reject_d;
            busy_q      <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign txReject = tx_reject_q;
    assign txWord   = tx_word_q;
    assign txValid  = tx_valid_q;
    assign txLast   = tx_last_q;
    assign txDone   = tx_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pkt_transmitter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pkt_transmitter : directed self-checking bench for pkt_transmitter
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pkt_transmitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        send;
    logic [2:0]  tPacketType;
    logic [15:0] tSourceID, tSourceHops, tQValue, tEnergyLeft, tHopsFromCH, tChosenCH;
    logic        busy, txReject, txValid, txReady, txLast, txDone;
    logic [15:0] txWord;

    int total = 0;
    int bad   = 0;

    pkt_transmitter #(.WORD_WIDTH(16), .SEQ_WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .send        (send),
        .tPacketType (tPacketType),
        .tSourceID   (tSourceID),
        .tSourceHops (tSourceHops),
        .tQValue     (tQValue),
        .tEnergyLeft (tEnergyLeft),
        .tHopsFromCH (tHopsFromCH),
        .tChosenCH   (tChosenCH),
        .busy        (busy),
        .txReject    (txReject),
        .txWord      (txWord),
        .txValid     (txValid),
        .txReady     (txReady),
        .txLast      (txLast),
        .txDone      (txDone)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [15:0] w, input logic last);
        chk({tag, "_valid"}, {15'd0, txValid}, 16'd1);
        chk({tag, "_word"},  txWord, w);
        chk({tag, "_last"},  {15'd0, txLast}, {15'd0, last});
    endtask

    task automatic do_send(input logic [2:0] t, input logic [15:0] id, input logic [15:0] hops,
                           input logic [15:0] q, input logic [15:0] en, input logic [15:0] hfc,
                           input logic [15:0] ch);
        tPacketType = t; tSourceID = id; tSourceHops = hops; tQValue = q;
        tEnergyLeft = en; tHopsFromCH = hfc; tChosenCH = ch;
        send = 1'b1;
        step();
        send = 1'b0;
    endtask

    initial begin
        logic [15:0] data_w [8];
        logic [15:0] hdr;
        rst = 1'b1; send = 1'b0; txReady = 1'b1; tPacketType = 3'd0;
        tSourceID = '0; tSourceHops = '0; tQValue = '0; tEnergyLeft = '0;
        tHopsFromCH = '0; tChosenCH = '0;

        // Reset state
        #2;
        chk("rst_valid",  {15'd0, txValid},  16'd0);
        chk("rst_word",   txWord,            16'd0);
        chk("rst_last",   {15'd0, txLast},   16'd0);
        chk("rst_busy",   {15'd0, busy},     16'd0);
        chk("rst_done",   {15'd0, txDone},   16'd0);
        chk("rst_reject", {15'd0, txReject}, 16'd0);
        step();
        rst = 1'b0;
        step();

        // HELLO, seq 0
        do_send(3'd0, 16'h0005, 16'h0003, 16'h0, 16'h0, 16'h0, 16'h0);
        chk("hello_busy", {15'd0, busy}, 16'd1);
        chk_word("hello_hdr", 16'h01A0, 1'b0); step();
        chk_word("hello_id",  16'h0005, 1'b0); step();
        chk_word("hello_hops", 16'h0003, 1'b0); step();
        chk_word("hello_csum", 16'h01A6, 1'b1); step();
        chk("hello_done",  {15'd0, txDone},  16'd1);
        chk("hello_idle",  {15'd0, busy},    16'd0);
        chk("hello_vlow",  {15'd0, txValid}, 16'd0);
        step();
        chk("hello_done_pulse", {15'd0, txDone}, 16'd0);

        // Invalid type at idle
        do_send(3'd6, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        chk("inv_reject", {15'd0, txReject}, 16'd1);
        chk("inv_valid",  {15'd0, txValid},  16'd0);
        chk("inv_busy",   {15'd0, busy},     16'd0);
        step();
        chk("inv_reject_pulse", {15'd0, txReject}, 16'd0);

        // JOIN, seq 1, with a send attempted mid-packet
        do_send(3'd3, 16'h0011, 16'hAAAA, 16'h0200, 16'h0F00, 16'hBBBB, 16'h0007);
        chk_word("join_hdr", 16'h76C1, 1'b0);
        send = 1'b1; tPacketType = 3'd0;
        step();
        send = 1'b0;
        chk("busy_reject", {15'd0, txReject}, 16'd1);
        chk_word("join_id", 16'h0011, 1'b0); step();
        chk("busy_reject_pulse", {15'd0, txReject}, 16'd0);
        chk_word("join_q",  16'h0200, 1'b0); step();
        chk_word("join_en", 16'h0F00, 1'b0); step();
        chk_word("join_ch", 16'h0007, 1'b0); step();
        chk_word("join_csum", 16'h7BD7, 1'b1); step();
        chk("join_done", {15'd0, txDone}, 16'd1);
        step();

        // DATA, seq 2, txReady pattern 1,0,0 per word; inputs scrambled after accept
        data_w[0] = 16'h9FE2; data_w[1] = 16'h1111; data_w[2] = 16'h2222; data_w[3] = 16'h3333;
        data_w[4] = 16'h4444; data_w[5] = 16'h5555; data_w[6] = 16'h6666; data_w[7] = 16'hE895;
        do_send(3'd4, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666);
        tSourceID = 16'hFFFF; tSourceHops = 16'hFFFF; tQValue = 16'hFFFF;
        tEnergyLeft = 16'hFFFF; tHopsFromCH = 16'hFFFF; tChosenCH = 16'hFFFF;
        for (int i = 0; i < 7; i++) begin
            txReady = 1'b0;
            chk_word($sformatf("data_w%0d_a", i), data_w[i], 1'b0); step();
            chk_word($sformatf("data_w%0d_b", i), data_w[i], 1'b0); step();
            txReady = 1'b1;
            chk_word($sformatf("data_w%0d_c", i), data_w[i], 1'b0); step();
        end
        txReady = 1'b0;
        chk_word("data_csum_a", data_w[7], 1'b1); step();
        chk_word("data_csum_b", data_w[7], 1'b1);
        // Send coincides with the checksum handshake and must be refused
        txReady = 1'b1; send = 1'b1; tPacketType = 3'd0;
        step();
        send = 1'b0;
        chk("csum_send_reject", {15'd0, txReject}, 16'd1);
        chk("data_done",        {15'd0, txDone},   16'd1);
        chk("data_idle",        {15'd0, busy},     16'd0);
        chk("data_vlow",        {15'd0, txValid},  16'd0);
        step();

        // DATA seq 3, reset during payload
        do_send(3'd4, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006);
        chk_word("rdata_hdr", 16'h9FE3, 1'b0);
        step(); step();
        chk("rdata_in_payload", {15'd0, busy}, 16'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {15'd0, txValid}, 16'd0);
        chk("mid_rst_busy",  {15'd0, busy},    16'd0);
        chk("mid_rst_word",  txWord,           16'd0);
        step();
        rst = 1'b0;
        step();

        // 17 back-to-back HELLOs, each send on the txDone cycle
        do_send(3'd0, 16'h0000, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0);
        for (int k = 0; k < 17; k++) begin
            hdr = 16'h01A0 | 16'(k % 16);
            chk_word($sformatf("wrap%0d_hdr", k),  hdr, 1'b0); step();
            chk_word($sformatf("wrap%0d_id", k),   16'(k), 1'b0); step();
            chk_word($sformatf("wrap%0d_hops", k), 16'h0100, 1'b0); step();
            chk_word($sformatf("wrap%0d_csum", k), hdr ^ 16'(k) ^ 16'h0100, 1'b1); step();
            chk($sformatf("wrap%0d_done", k), {15'd0, txDone}, 16'd1);
            chk($sformatf("wrap%0d_idle", k), {15'd0, busy},   16'd0);
            if (k < 16) begin
                do_send(3'd0, 16'(k + 1), 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0);
                chk($sformatf("wrap%0d_accept", k), {15'd0, txReject}, 16'd0);
            end else begin
                step();
            end
        end
        chk("final_idle", {15'd0, txValid}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
